// File: rtl/uart_tx_drain.sv
// rtl/uart_tx_drain.sv - drains a CPU transmit ring one byte at a time as 8N1 UART frames
// Owns the ring head pointer; counts completed frames on LED.
module uart_tx_drain #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PTR_W        = 9
) (
  input  logic             CLK,
  input  logic             INITIALIZE,
  input  logic [PTR_W-1:0] TAIL,
  input  logic [7:0]       RD_DATA,
  output logic [PTR_W-1:0] HEAD,
  output logic             UART_TX,
  output logic             BUSY,
  output logic [7:0]       LED
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [PTR_W-1:0] head_q, head_nx;
  logic [7:0]       shift_q, shift_nx;
  logic [15:0]      baud_q, baud_nx;
  logic [2:0]       bit_q, bit_nx;
  logic             tx_q, tx_nx;
  logic [7:0]       led_q, led_nx;
  logic             baud_done;

  assign baud_done = (baud_q == BAUD_LAST);

  always_ff @(posedge CLK or posedge INITIALIZE) begin
    if (INITIALIZE) begin
      state   <= IDLE;
      head_q  <= '0;
      shift_q <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      led_q   <= '0;
    end else begin
      state   <= state_nx;
      head_q  <= head_nx;
      shift_q <= shift_nx;
      baud_q  <= baud_nx;
      bit_q   <= bit_nx;
      tx_q    <= tx_nx;
      led_q   <= led_nx;
    end
  end

  // tx_nx is the line level for the state being entered, so UART_TX stays a pure flop output.
  always_comb begin
    state_nx = state;
    head_nx  = head_q;
    shift_nx = shift_q;
    baud_nx  = baud_q + 16'd1;
    bit_nx   = bit_q;
    tx_nx    = tx_q;
    led_nx   = led_q;
    case (state)
      IDLE: begin
        baud_nx = '0;
        tx_nx   = 1'b1;
        if (head_q != TAIL) begin
          shift_nx = RD_DATA;
          head_nx  = head_q + PTR_W'(1);
          tx_nx    = 1'b0;
          state_nx = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_nx  = '0;
          bit_nx   = '0;
          tx_nx    = shift_q[0];
          state_nx = DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_nx  = '0;
          shift_nx = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            tx_nx    = 1'b1;
            state_nx = STOP;
          end else begin
            bit_nx = bit_q + 3'd1;
            tx_nx  = shift_q[1];
          end
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_nx  = '0;
          led_nx   = led_q + 8'd1;
          tx_nx    = 1'b1;
          state_nx = IDLE;
        end
      end
      default: begin
        tx_nx    = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end

  assign HEAD    = head_q;
  assign UART_TX = tx_q;
  assign BUSY    = (state != IDLE);
  assign LED     = led_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// tb/tb_uart_tx_drain.sv - self-checking bench for uart_tx_drain with a ring model and frame scoreboard
module tb_uart_tx_drain;
  localparam int CPB = 4;
  localparam int PW  = 9;

  logic          CLK = 1'b0;
  logic          INITIALIZE;
  logic [PW-1:0] TAIL;
  logic [PW-1:0] HEAD;
  logic [7:0]    RD_DATA;
  logic [7:0]    LED;
  logic          UART_TX;
  logic          BUSY;

  logic [7:0] ring [0:511];
  assign RD_DATA = ring[HEAD];

  always #5 CLK = ~CLK;

  uart_tx_drain #(.CLKS_PER_BIT(CPB), .PTR_W(PW)) dut (
    .CLK(CLK), .INITIALIZE(INITIALIZE), .TAIL(TAIL), .RD_DATA(RD_DATA),
    .HEAD(HEAD), .UART_TX(UART_TX), .BUSY(BUSY), .LED(LED)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         n_starts = 0;
  int         start_q[$];
  logic [7:0] sb_q[$];

  typedef struct {
    logic [7:0]    data;
    logic [PW-1:0] head_after;
    logic [7:0]    led_after;
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Line decoder: samples mid-bit on the falling clock edge and scores each frame.
  initial begin : monitor
    logic       active;
    int         cnt;
    logic [7:0] rx;
    active = 1'b0;
    cnt = 0;
    rx = '0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (INITIALIZE) begin
        active = 1'b0;
      end else if (!active) begin
        if (UART_TX === 1'b0) begin
          active = 1'b1;
          cnt = 0;
          n_starts++;
          start_q.push_back(cyc);
        end
      end else begin
        cnt++;
      end
      if (active && (cnt % CPB) == CPB / 2) begin
        if (cnt / CPB == 0) begin
          check("start_bit", 32'(UART_TX), 32'd0);
        end else if (cnt / CPB <= 8) begin
          rx[cnt / CPB - 1] = UART_TX;
        end else begin
          check("stop_bit", 32'(UART_TX), 32'd1);
          if (sb_q.size() == 0) check("unexpected_frame", 32'(rx), 32'hFFFF_FFFF);
          else check("frame_byte", 32'(rx), 32'(sb_q.pop_front()));
          active = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_head(input logic [PW-1:0] v, input int budget);
    int k = 0;
    while (HEAD !== v && k < budget) begin tick(); k++; end
    check("wait_head", 32'(HEAD), 32'(v));
  endtask

  task automatic wait_led(input logic [7:0] v, input int budget);
    int k = 0;
    while (LED !== v && k < budget) begin tick(); k++; end
    check("wait_led", 32'(LED), 32'(v));
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((BUSY !== 1'b0 || HEAD !== TAIL) && k < budget) begin tick(); k++; end
    check("wait_idle_busy", 32'(BUSY), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    INITIALIZE = 1'b1;
    TAIL = '0;
    @(negedge CLK);
    INITIALIZE = 1'b0;
    tick();
  endtask

  initial begin
    int         errs;
    int         starts_before;
    logic [9:0] frame;
    logic [7:0] b;

    for (int i = 0; i < 512; i++) ring[i] = 8'h00;
    INITIALIZE = 1'b1;
    TAIL = '0;
    repeat (2) tick();
    INITIALIZE = 1'b0;
    repeat (2) tick();

    // 1: asynchronous reset between edges, then a quiet line
    #2 INITIALIZE = 1'b1;
    #1;
    check("rst_head", 32'(HEAD), 32'd0);
    check("rst_tx", 32'(UART_TX), 32'd1);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_led", 32'(LED), 32'd0);
    @(negedge CLK);
    INITIALIZE = 1'b0;
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (UART_TX !== 1'b1 || HEAD !== '0 || BUSY !== 1'b0) errs++;
    end
    check("idle_100_cycles", 32'(errs), 32'd0);

    // 2: single byte, cycle-exact waveform
    ring[0] = 8'hA5;
    sb_q.push_back(8'hA5);
    TAIL = 9'd1;
    tick();
    check("single_head", 32'(HEAD), 32'd1);
    frame = {1'b1, 8'hA5, 1'b0};
    errs = 0;
    for (int j = 0; j < 10 * CPB; j++) begin
      if (UART_TX !== frame[j / CPB] || BUSY !== 1'b1) errs++;
      tick();
    end
    check("single_waveform", 32'(errs), 32'd0);
    check("single_busy_end", 32'(BUSY), 32'd0);
    check("single_led", 32'(LED), 32'd1);
    check("single_tx_end", 32'(UART_TX), 32'd1);

    // 3: back-to-back frames from a vector table
    do_reset();
    vecs[0] = '{8'h00, 9'd1, 8'd1};
    vecs[1] = '{8'hFF, 9'd2, 8'd2};
    vecs[2] = '{8'h55, 9'd3, 8'd3};
    vecs[3] = '{8'h80, 9'd4, 8'd4};
    start_q.delete();
    for (int i = 0; i < 4; i++) begin
      ring[i] = vecs[i].data;
      sb_q.push_back(vecs[i].data);
    end
    TAIL = 9'd4;
    for (int i = 0; i < 4; i++) begin
      wait_head(vecs[i].head_after, 60);
      wait_led(vecs[i].led_after, 60);
    end
    repeat (3) tick();
    check("b2b_frames", 32'(start_q.size()), 32'd4);
    for (int i = 1; i < 4 && i < start_q.size(); i++)
      check("b2b_spacing", 32'(start_q[i] - start_q[i-1]), 32'(10 * CPB + 1));
    check("b2b_idle", 32'(BUSY), 32'd0);

    // 5: reset during DATA bit 3 of 0x3C
    ring[4] = 8'h3C;
    TAIL = 9'd5;
    wait_head(9'd5, 10);
    repeat (17) @(posedge CLK);
    #1;
    check("mid_busy_before", 32'(BUSY), 32'd1);
    #2 INITIALIZE = 1'b1;
    #1;
    check("mid_tx", 32'(UART_TX), 32'd1);
    check("mid_head", 32'(HEAD), 32'd0);
    check("mid_led", 32'(LED), 32'd0);
    check("mid_busy", 32'(BUSY), 32'd0);
    TAIL = '0;
    @(negedge CLK);
    INITIALIZE = 1'b0;
    starts_before = n_starts;
    repeat (60) tick();
    check("mid_no_frame", 32'(n_starts - starts_before), 32'd0);
    check("mid_head_hold", 32'(HEAD), 32'd0);
    ring[0] = 8'h3C;
    sb_q.push_back(8'h3C);
    TAIL = 9'd1;
    wait_idle(60);
    check("mid_fresh_head", 32'(HEAD), 32'd1);
    check("mid_fresh_led", 32'(LED), 32'd1);

    // 6: LED rollover over 256 frames
    do_reset();
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom_range(0, 255));
      ring[i] = b;
      sb_q.push_back(b);
    end
    TAIL = 9'd256;
    wait_led(8'd255, 256 * (10 * CPB + 1) + 20);
    check("roll_head_255", 32'(HEAD), 32'd255);
    wait_led(8'd0, 60);
    check("roll_head_256", 32'(HEAD), 32'd256);
    check("roll_busy", 32'(BUSY), 32'd0);

    // 4: drain to 510, then wrap through 511 -> 0 -> 2
    for (int i = 256; i < 510; i++) begin
      b = 8'($urandom_range(0, 255));
      ring[i] = b;
      sb_q.push_back(b);
    end
    TAIL = 9'd510;
    wait_idle(254 * (10 * CPB + 1) + 20);
    check("wrap_head_510", 32'(HEAD), 32'd510);
    check("wrap_led", 32'(LED), 32'd254);
    ring[510] = 8'h11; ring[511] = 8'h22; ring[0] = 8'h33; ring[1] = 8'h44;
    sb_q.push_back(8'h11); sb_q.push_back(8'h22);
    sb_q.push_back(8'h33); sb_q.push_back(8'h44);
    TAIL = 9'd2;
    wait_head(9'd511, 5);
    wait_head(9'd0, 60);
    wait_head(9'd1, 60);
    wait_head(9'd2, 60);
    wait_idle(60);
    repeat (5) tick();
    check("wrap_final_head", 32'(HEAD), 32'd2);
    check("wrap_final_led", 32'(LED), 32'd2);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
